fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_queue.sv | 93 +++++++++
 tb/tb_fetch_queue.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the fetch, fetch-queue and decode stages.
//   PC_W          - program counter width
//   INSTR_W       - instruction word width
//   fetch_entry_t - one fetched instruction {pc, instr}
package fetch_pkg;

  localparam int PC_W    = 36;
  localparam int INSTR_W = 32;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Sequential successor of a PC, wrapping at the PC width.
  function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
    return pc + PC_W'(4);
  endfunction

endpackage : fetch_pkg

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry FIFO between the fetch and decode stages.
//   clk, rst        - clock (rising edge) and asynchronous active-high reset
//   enq_valid/ready - fetch presents {enq_pc, enq_instr}; accepted when both high
//   deq_valid/ready - head {deq_pc, deq_instr} consumed when both high
//   deq_pc_plus_4   - head PC + 4, wrapped to PC_W bits
//   flush           - branch redirect / halt: empties the queue next cycle
//   count           - number of occupied entries (0..DEPTH)
// Full-queue accept on simultaneous dequeue and empty-queue bypass are both
// deliberately absent, keeping the ready/valid paths independent of each other.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int PC_W    = fetch_pkg::PC_W,
  parameter int INSTR_W = fetch_pkg::INSTR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq_valid,
  input  logic [PC_W-1:0]          enq_pc,
  input  logic [INSTR_W-1:0]       enq_instr,
  output logic                     enq_ready,
  output logic                     deq_valid,
  output logic [PC_W-1:0]          deq_pc,
  output logic [INSTR_W-1:0]       deq_instr,
  output logic [PC_W-1:0]          deq_pc_plus_4,
  input  logic                     deq_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_enq;
  logic w_deq;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == CW'(0));

  assign enq_ready = ~w_full  & ~flush;
  assign deq_valid = ~w_empty & ~flush;

  // Both handshakes already exclude flush, so a flush cycle neither writes nor pops.
  assign w_enq = enq_valid & enq_ready;
  assign w_deq = deq_valid & deq_ready;

  assign deq_pc        = r_mem[r_rd_ptr].pc;
  assign deq_instr     = r_mem[r_rd_ptr].instr;
  assign deq_pc_plus_4 = pc_next(r_mem[r_rd_ptr].pc);
  assign count         = r_count;

  // Pointer and occupancy state; DEPTH is a power of 2 so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= AW'(0);
      r_rd_ptr <= AW'(0);
      r_count  <= CW'(0);
    end else if (flush) begin
      r_wr_ptr <= AW'(0);
      r_rd_ptr <= AW'(0);
      r_count  <= CW'(0);
    end else begin
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage: written only on an accepted enqueue, never reset.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem[r_wr_ptr].pc    <= enq_pc;
      r_mem[r_wr_ptr].instr <= enq_instr;
    end
  end

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios plus randomized traffic, all checked
// against a queue-based reference model of the fetch queue.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int PC_W  = 36;
  localparam int IW    = 32;

  typedef struct {
    logic [PC_W-1:0] pc;
    logic [IW-1:0]   instr;
  } ent_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            enq_valid;
  logic [PC_W-1:0] enq_pc;
  logic [IW-1:0]   enq_instr;
  logic            enq_ready;
  logic            deq_valid;
  logic [PC_W-1:0] deq_pc;
  logic [IW-1:0]   deq_instr;
  logic [PC_W-1:0] deq_pc_plus_4;
  logic            deq_ready;
  logic            flush;
  logic [2:0]      count;

  int n_cmp  = 0;
  int n_fail = 0;

  ent_t model_q[$];

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_pc(enq_pc), .enq_instr(enq_instr), .enq_ready(enq_ready),
    .deq_valid(deq_valid), .deq_pc(deq_pc), .deq_instr(deq_instr),
    .deq_pc_plus_4(deq_pc_plus_4), .deq_ready(deq_ready),
    .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  // Advance one clock: update the reference model from the inputs held
  // across this edge, then settle 1 time unit past the edge.
  task automatic tick();
    bit e;
    bit d;
    @(posedge clk);
    if (flush) begin
      model_q.delete();
    end else begin
      e = enq_valid && (model_q.size() < DEPTH);
      d = deq_ready && (model_q.size() > 0);
      if (d) void'(model_q.pop_front());
      if (e) model_q.push_back('{pc: enq_pc, instr: enq_instr});
    end
    #1;
  endtask

  task automatic push(input logic [PC_W-1:0] pc, input logic [IW-1:0] instr);
    enq_valid = 1'b1; enq_pc = pc; enq_instr = instr;
    tick();
    enq_valid = 1'b0;
  endtask

  task automatic drain();
    deq_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) tick();
    deq_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enq_valid = 1'b0; deq_ready = 1'b0; flush = 1'b0;
    enq_pc = '0; enq_instr = '0;
    #22;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (count !== 3'd0 || deq_valid !== 1'b0 || enq_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset: count=%0d deq_valid=%b enq_ready=%b, required 0/0/1", count, deq_valid, enq_ready);
    end
  endtask

  task automatic test_single();
    push(36'h0, 32'h11111111);
    n_cmp++;
    if (deq_valid !== 1'b1 || deq_pc !== 36'h0 || deq_pc_plus_4 !== 36'h4 ||
        deq_instr !== 32'h11111111 || count !== 3'd1) begin
      n_fail++;
      $display("FAIL single: valid=%b pc=%h pc4=%h instr=%h count=%0d, required 1/0/4/11111111/1",
               deq_valid, deq_pc, deq_pc_plus_4, deq_instr, count);
    end
    drain();
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) push(PC_W'(4 * i), 32'hA000_0000 + IW'(i));
    n_cmp++;
    if (count !== 3'd4 || enq_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full: count=%0d enq_ready=%b, required 4/0", count, enq_ready);
    end
    push(36'h10, 32'hDEAD_BEEF);
    n_cmp++;
    if (count !== 3'd4) begin
      n_fail++;
      $display("FAIL fifth_enq: count=%0d, required 4", count);
    end
    deq_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++;
      if (deq_valid !== 1'b1 || deq_pc !== PC_W'(4 * i) || deq_instr !== 32'hA000_0000 + IW'(i)) begin
        n_fail++;
        $display("FAIL drain_order[%0d]: valid=%b pc=%h instr=%h, required 1/%h/%h",
                 i, deq_valid, deq_pc, deq_instr, PC_W'(4 * i), 32'hA000_0000 + IW'(i));
      end
      tick();
    end
    deq_ready = 1'b0;
    n_cmp++;
    if (count !== 3'd0 || deq_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drained: count=%0d deq_valid=%b, required 0/0", count, deq_valid);
    end
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < DEPTH; i++) push(PC_W'(36'h100 + 4 * i), IW'(i));
    enq_valid = 1'b1; enq_pc = 36'h999; enq_instr = 32'h99; deq_ready = 1'b1;
    tick();
    enq_valid = 1'b0; deq_ready = 1'b0;
    n_cmp++;
    if (count !== 3'd3 || enq_ready !== 1'b1 || deq_pc !== 36'h104) begin
      n_fail++;
      $display("FAIL full_simul: count=%0d enq_ready=%b head=%h, required 3/1/104", count, enq_ready, deq_pc);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int errs = 0;
    push(36'h1000, 32'h0);
    push(36'h1004, 32'h1);
    enq_valid = 1'b1; deq_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (deq_pc !== PC_W'(36'h1000 + 4 * i) || count !== 3'd2 || deq_pc !== model_q[0].pc) errs++;
      enq_pc = PC_W'(36'h1008 + 4 * i); enq_instr = IW'(i + 2);
      tick();
    end
    enq_valid = 1'b0; deq_ready = 1'b0;
    n_cmp++;
    if (errs != 0 || count !== 3'd2 || deq_pc !== PC_W'(36'h1028)) begin
      n_fail++;
      $display("FAIL steady: errs=%0d count=%0d head=%h, required 0/2/1028", errs, count, deq_pc);
    end
    drain();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) push(PC_W'(36'h2000 + 4 * i), IW'(i));
    flush = 1'b1; enq_valid = 1'b1; enq_pc = 36'hBAD; enq_instr = 32'hBAD; deq_ready = 1'b1;
    #1;
    n_cmp++;
    if (enq_ready !== 1'b0 || deq_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_gate: enq_ready=%b deq_valid=%b, required 0/0", enq_ready, deq_valid);
    end
    tick();
    flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
    n_cmp++;
    if (count !== 3'd0 || deq_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush: count=%0d deq_valid=%b, required 0/0", count, deq_valid);
    end
    push(36'h3000, 32'h3);
    n_cmp++;
    if (count !== 3'd1 || deq_pc !== 36'h3000 || deq_instr !== 32'h3) begin
      n_fail++;
      $display("FAIL post_flush: count=%0d pc=%h instr=%h, required 1/3000/3", count, deq_pc, deq_instr);
    end
    drain();
  endtask

  task automatic test_pc_wrap_and_reset();
    push(36'hFFFFFFFFC, 32'h77);
    push(36'h4000, 32'h78);
    n_cmp++;
    if (deq_pc !== 36'hFFFFFFFFC || deq_pc_plus_4 !== 36'h0 || count !== 3'd2) begin
      n_fail++;
      $display("FAIL pc_wrap: pc=%h pc4=%h count=%0d, required FFFFFFFFC/0/2", deq_pc, deq_pc_plus_4, count);
    end
    #2;
    rst = 1'b1;
    model_q.delete();
    #1;
    n_cmp++;
    if (count !== 3'd0 || deq_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: count=%0d deq_valid=%b, required 0/0", count, deq_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (count !== 3'd0 || enq_ready !== 1'b1 || deq_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: count=%0d enq_ready=%b deq_valid=%b, required 0/1/0", count, enq_ready, deq_valid);
    end
  endtask

  task automatic test_random();
    logic [63:0]     rnd;
    logic [PC_W-1:0] exp_pc4;
    bit              exp_v;
    bit              exp_r;
    for (int c = 0; c < 500; c++) begin
      rnd       = {$urandom, $urandom};
      enq_valid = ($urandom_range(0, 3) != 0);
      enq_pc    = rnd[PC_W-1:0];
      enq_instr = $urandom;
      deq_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      #1;
      exp_v = (model_q.size() != 0) && !flush;
      exp_r = (model_q.size() != DEPTH) && !flush;
      n_cmp++;
      if (count !== 3'(model_q.size()) || deq_valid !== exp_v || enq_ready !== exp_r) begin
        n_fail++;
        $display("FAIL rand_ctl[%0d]: count=%0d valid=%b ready=%b, required %0d/%b/%b",
                 c, count, deq_valid, enq_ready, model_q.size(), exp_v, exp_r);
      end
      if (model_q.size() != 0) begin
        exp_pc4 = model_q[0].pc + PC_W'(4);
        n_cmp++;
        if (deq_pc !== model_q[0].pc || deq_instr !== model_q[0].instr || deq_pc_plus_4 !== exp_pc4) begin
          n_fail++;
          $display("FAIL rand_head[%0d]: pc=%h instr=%h pc4=%h, required %h/%h/%h",
                   c, deq_pc, deq_instr, deq_pc_plus_4, model_q[0].pc, model_q[0].instr, exp_pc4);
        end
      end
      tick();
    end
    enq_valid = 1'b0; deq_ready = 1'b0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_full_simul();
    test_back_to_back();
    test_flush();
    test_pc_wrap_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule : tb_fetch_queue
